gpio_in_sync: RTL and testbench

//   Input-direction companion of the GPIO output register. Takes asynchronous

---
 rtl/gpio_in_sync.sv | 77 +++++++
 tb/tb_gpio_in_sync.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_sync.sv
// GPIO input path: two-flop synchroniser, per-bit debounce, and sticky edge flags
// with write-1-to-clear and a maskable interrupt.
module gpio_in_sync #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned EDGE_SEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] GPIO_In,
  input  logic                  edge_clr_en,
  input  logic [DATA_WIDTH-1:0] edge_clr_mask,
  input  logic [DATA_WIDTH-1:0] irq_mask,
  output logic [DATA_WIDTH-1:0] GPIO_toMem,
  output logic [DATA_WIDTH-1:0] edge_flags,
  output logic                  irq
);

  localparam int unsigned   CntW    = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);
  localparam logic          RiseEn  = (EDGE_SEL != 1);
  localparam logic          FallEn  = (EDGE_SEL != 0);

  logic [DATA_WIDTH-1:0]           s1_q, s2_q;
  logic [DATA_WIDTH-1:0]           level_q, level_d;
  logic [DATA_WIDTH-1:0]           flags_q, flags_d;
  logic [DATA_WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]           upd;
  logic [DATA_WIDTH-1:0]           set_ev;
  logic [DATA_WIDTH-1:0]           clr;

  // A new level must be seen on DB_CYCLES consecutive edges before it is accepted;
  // any return to the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    upd     = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          upd[i]     = 1'b1;
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    set_ev  = upd & ((s2_q & {DATA_WIDTH{RiseEn}}) | (~s2_q & {DATA_WIDTH{FallEn}}));
    clr     = edge_clr_en ? edge_clr_mask : '0;
    // Set is ORed in after the clear so a coincident event is never lost.
    flags_d = (flags_q & ~clr) | set_ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= GPIO_In;
      s2_q    <= s1_q;
      level_q <= level_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GPIO_toMem = level_q;
  assign edge_flags = flags_q;
  assign irq        = |(flags_q & irq_mask);

endmodule

// File: tb/tb_gpio_in_sync.sv
// Bench for gpio_in_sync: directed scenarios plus random pin activity checked
// against a sample-history reference model.
module tb_gpio_in_sync;

  localparam int W  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gpio_in;
  logic         clr_en;
  logic [W-1:0] clr_mask;
  logic [W-1:0] irq_mask;
  logic [W-1:0] to_mem, flags, to_mem1, flags1;
  logic         irq, irq1;

  always #5 clk = ~clk;

  gpio_in_sync #(.DATA_WIDTH(W), .DB_CYCLES(DB), .EDGE_SEL(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .GPIO_In      (gpio_in),
    .edge_clr_en  (clr_en),
    .edge_clr_mask(clr_mask),
    .irq_mask     (irq_mask),
    .GPIO_toMem   (to_mem),
    .edge_flags   (flags),
    .irq          (irq)
  );

  gpio_in_sync #(.DATA_WIDTH(W), .DB_CYCLES(DB), .EDGE_SEL(1)) dut_fall (
    .clk          (clk),
    .rst          (rst),
    .GPIO_In      (gpio_in),
    .edge_clr_en  (clr_en),
    .edge_clr_mask(clr_mask),
    .irq_mask     (irq_mask),
    .GPIO_toMem   (to_mem1),
    .edge_flags   (flags1),
    .irq          (irq1)
  );

  // Reference model: history of pin samples, one per clock edge.
  logic [W-1:0] samp[$];
  logic [W-1:0] m_out, m_flags, m_flags1;
  int checks   = 0;
  int failures = 0;

  task automatic model_reset();
    samp.delete();
    for (int j = 0; j < DB + 2; j++) samp.push_back('0);
    m_out    = '0;
    m_flags  = '0;
    m_flags1 = '0;
  endtask

  // A bit flips once the last DB synchronised samples (each two edges old) all
  // show the opposite level.
  task automatic model_edge();
    logic [W-1:0] set_both, set_fall, c;
    logic want, all;
    int n;
    samp.push_back(gpio_in);
    n = samp.size();
    set_both = '0;
    set_fall = '0;
    for (int i = 0; i < W; i++) begin
      want = ~m_out[i];
      all  = 1'b1;
      for (int j = 0; j < DB; j++) if (samp[n-3-j][i] !== want) all = 1'b0;
      if (all) begin
        m_out[i]    = want;
        set_both[i] = 1'b1;
        set_fall[i] = ~want;
      end
    end
    c        = clr_en ? clr_mask : '0;
    m_flags  = (m_flags & ~c) | set_both;
    m_flags1 = (m_flags1 & ~c) | set_fall;
    if (samp.size() > 32) void'(samp.pop_front());
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic apply_reset(input logic [W-1:0] pin);
    rst      = 1'b1;
    gpio_in  = pin;
    clr_en   = 1'b0;
    clr_mask = '0;
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    irq_mask = 8'hFF;
    apply_reset(8'hFF);
    rst = 1'b1;
    repeat (2) cycle();
    checks++;
    if (to_mem !== 8'h00 || flags !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got mem=%h flags=%h irq=%b exp 00 00 0", to_mem, flags, irq);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      checks++;
      if (k < 6 && to_mem !== 8'h00) begin
        failures++;
        $display("FAIL reset_latency_early k=%0d got=%h exp=00", k, to_mem);
      end else if (k == 6 && (to_mem !== 8'hFF || flags !== 8'hFF)) begin
        failures++;
        $display("FAIL reset_release got mem=%h flags=%h exp FF FF", to_mem, flags);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset(8'h00);
    repeat (3) cycle();
    gpio_in = 8'h01;
    repeat (3) cycle();
    gpio_in = 8'h00;
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (to_mem !== 8'h00 || flags !== 8'h00) begin
        failures++;
        $display("FAIL glitch k=%0d got mem=%h flags=%h exp 00 00", k, to_mem, flags);
      end
    end
  endtask

  task automatic test_level();
    irq_mask = 8'h01;
    gpio_in  = 8'hA5;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      checks++;
      if (k < 6 && (to_mem !== 8'h00 || irq !== 1'b0)) begin
        failures++;
        $display("FAIL level_early k=%0d got mem=%h irq=%b exp 00 0", k, to_mem, irq);
      end else if (k == 6 && (to_mem !== 8'hA5 || flags !== 8'hA5 || irq !== 1'b1)) begin
        failures++;
        $display("FAIL level got mem=%h flags=%h irq=%b exp A5 A5 1", to_mem, flags, irq);
      end
    end
    irq_mask = 8'h02;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_masked got=%b exp=0", irq);
    end
    irq_mask = 8'h01;
  endtask

  task automatic test_set_wins();
    gpio_in = 8'hA1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin
        clr_en   = 1'b1;
        clr_mask = 8'h04;
      end
      cycle();
    end
    checks++;
    if (to_mem !== 8'hA1 || flags !== 8'hA5) begin
      failures++;
      $display("FAIL set_wins got mem=%h flags=%h exp A1 A5", to_mem, flags);
    end
    clr_mask = 8'hA5;
    cycle();
    clr_en = 1'b0;
    checks++;
    if (flags !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL w1c got flags=%h irq=%b exp 00 0", flags, irq);
    end
  endtask

  task automatic test_falling_only();
    apply_reset(8'h00);
    gpio_in = 8'h08;
    repeat (10) cycle();
    checks++;
    if (to_mem1 !== 8'h08 || flags1[3] !== 1'b0 || flags !== 8'h08) begin
      failures++;
      $display("FAIL fall_after_rise got mem=%h f1=%h f2=%h exp 08 00 08", to_mem1, flags1, flags);
    end
    gpio_in = 8'h00;
    repeat (10) cycle();
    checks++;
    if (to_mem1 !== 8'h00 || flags1 !== 8'h08) begin
      failures++;
      $display("FAIL fall_after_fall got mem=%h f1=%h exp 00 08", to_mem1, flags1);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(8'h00);
    repeat (2) cycle();
    gpio_in = 8'h02;
    repeat (3) cycle();
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (to_mem !== 8'h00 || flags !== 8'h00) begin
      failures++;
      $display("FAIL async_reset got mem=%h flags=%h exp 00 00", to_mem, flags);
    end
    cycle();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      checks++;
      if (to_mem[1] !== (k == 6)) begin
        failures++;
        $display("FAIL reset_restart k=%0d got=%b exp=%b", k, to_mem[1], (k == 6));
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] flip;
    apply_reset(8'h00);
    for (int k = 0; k < 400; k++) begin
      flip = '0;
      for (int i = 0; i < W; i++) flip[i] = ($urandom_range(5) == 0);
      gpio_in  = gpio_in ^ flip;
      clr_en   = ($urandom_range(3) == 0);
      clr_mask = W'($urandom);
      irq_mask = W'($urandom);
      cycle();
      checks++;
      if (to_mem !== m_out || to_mem1 !== m_out || flags !== m_flags || flags1 !== m_flags1
          || irq !== |(m_flags & irq_mask)) begin
        failures++;
        $display("FAIL random k=%0d got mem=%h f=%h f1=%h irq=%b exp mem=%h f=%h f1=%h irq=%b",
                 k, to_mem, flags, flags1, irq, m_out, m_flags, m_flags1,
                 |(m_flags & irq_mask));
      end
    end
    clr_en = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    gpio_in  = '0;
    clr_en   = 1'b0;
    clr_mask = '0;
    irq_mask = '0;
    test_reset();
    test_glitch();
    test_level();
    test_set_wins();
    test_falling_only();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
